// File: rtl/dct_seq_ctrl.sv
// Sequencing controller for the time-multiplexed 8-point DCT datapath:
// sample load, stage/pair/sub-cycle walk over the butterflies, coefficient readout.
module dct_seq_ctrl #(
  parameter int NPTS   = 8,
  parameter int NSTAGE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [2:0] wr_idx,
  output logic [1:0] stg,
  output logic [1:0] pr_idx,
  output logic [1:0] cap_q,
  output logic       wb_en,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] rd_idx,
  output logic       done,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here depend on state only, never on the partner.
  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NPTS - 1);
  localparam logic [1:0] LAST_STG = 2'(NSTAGE - 1);

  state_t     state_q, state_d;
  logic [2:0] lc_q, lc_d;
  logic [2:0] oc_q, oc_d;
  logic [1:0] stg_q, stg_d;
  logic [1:0] pr_q, pr_d;
  logic       sc_q, sc_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    oc_d    = oc_q;
    stg_d   = stg_q;
    pr_d    = pr_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (lc_q == LAST_IDX) begin
            lc_d    = 3'd0;
            state_d = ST_COMPUTE;
          end else begin
            lc_d = lc_q + 3'd1;
          end
        end
      end
      ST_COMPUTE: begin
        if (!sc_q) begin
          sc_d = 1'b1;
        end else begin
          sc_d = 1'b0;
          if (pr_q == 2'd3) begin
            pr_d = 2'd0;
            if (stg_q == LAST_STG) begin
              stg_d   = 2'd0;
              state_d = ST_OUT;
            end else begin
              stg_d = stg_q + 2'd1;
            end
          end else begin
            pr_d = pr_q + 2'd1;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (oc_q == LAST_IDX) begin
            oc_d    = 3'd0;
            state_d = ST_LOAD;
            done_d  = 1'b1;
          end else begin
            oc_d = oc_q + 3'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      lc_q    <= 3'd0;
      oc_q    <= 3'd0;
      stg_q   <= 2'd0;
      pr_q    <= 2'd0;
      sc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      oc_q    <= oc_d;
      stg_q   <= stg_d;
      pr_q    <= pr_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
    end
  end

  // Counters are cleared on every state exit, so stg/pr_idx read 0 outside COMPUTE.
  assign in_ready  = (state_q == ST_LOAD);
  assign wr_en     = in_valid & in_ready;
  assign wr_idx    = lc_q;
  assign stg       = stg_q;
  assign pr_idx    = pr_q;
  assign cap_q     = (state_q == ST_COMPUTE) ? {1'b0, sc_q} : 2'd3;
  assign wb_en     = (state_q == ST_COMPUTE) & sc_q;
  assign busy      = (state_q != ST_LOAD);
  assign out_valid = (state_q == ST_OUT);
  assign rd_idx    = oc_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Directed bench for dct_seq_ctrl: NSTAGE=3 instance plus an NSTAGE=1 instance.
module tb_dct_seq_ctrl;

  localparam logic [1:0] S_LOAD = 2'd0, S_COMP = 2'd1, S_OUT = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       in_valid0, out_ready0;
  logic       in_ready0, wr_en0, wb_en0, busy0, out_valid0, done0;
  logic [2:0] wr_idx0, rd_idx0;
  logic [1:0] stg0, pr_idx0, cap_q0, state0;

  logic       in_valid1, out_ready1;
  logic       in_ready1, wr_en1, wb_en1, busy1, out_valid1, done1;
  logic [2:0] wr_idx1, rd_idx1;
  logic [1:0] stg1, pr_idx1, cap_q1, state1;

  dct_seq_ctrl #(.NPTS(8), .NSTAGE(3)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .wr_en(wr_en0), .wr_idx(wr_idx0), .stg(stg0), .pr_idx(pr_idx0),
    .cap_q(cap_q0), .wb_en(wb_en0), .busy(busy0), .out_valid(out_valid0),
    .out_ready(out_ready0), .rd_idx(rd_idx0), .done(done0), .dbg_state(state0)
  );

  dct_seq_ctrl #(.NPTS(8), .NSTAGE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .wr_en(wr_en1), .wr_idx(wr_idx1), .stg(stg1), .pr_idx(pr_idx1),
    .cap_q(cap_q1), .wb_en(wb_en1), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready1), .rd_idx(rd_idx1), .done(done1), .dbg_state(state1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({in_ready0, wr_en0, wr_idx0, cap_q0, wb_en0, busy0, out_valid0, rd_idx0, done0, stg0, pr_idx0, state0}
        !== {1'b1, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, S_LOAD}) begin
      n_errors++; $display("FAIL reset_initial: in_ready=%b wr_en=%b wr_idx=%0d cap=%0d wb=%b busy=%b ov=%b rd=%0d done=%b st=%0d",
        in_ready0, wr_en0, wr_idx0, cap_q0, wb_en0, busy0, out_valid0, rd_idx0, done0, state0);
    end
    rst_n = 1'b1;
    in_valid0 = 1'b1;
    repeat (8) tick();
    in_valid0 = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (stg0 !== 2'd1 || state0 !== S_COMP) begin
      n_errors++; $display("FAIL reset_pre_stg: stg=%0d state=%0d required stg=1 state=%0d", stg0, state0, S_COMP);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready0, wr_en0, wr_idx0, cap_q0, wb_en0, busy0, out_valid0, rd_idx0, done0, stg0, pr_idx0, state0}
        !== {1'b1, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, S_LOAD}) begin
      n_errors++; $display("FAIL reset_mid_compute: in_ready=%b cap=%0d wb=%b busy=%b stg=%0d pr=%0d state=%0d required reset values",
        in_ready0, cap_q0, wb_en0, busy0, stg0, pr_idx0, state0);
    end
    rst_n = 1'b1;
    in_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (wr_idx0 !== 3'(i) || wr_en0 !== 1'b1) begin
        n_errors++; $display("FAIL reset_reload[%0d]: wr_idx=%0d wr_en=%b required %0d 1", i, wr_idx0, wr_en0, i);
      end
      tick();
    end
    in_valid0 = 1'b0;
    pulse_reset();
  endtask

  task automatic test_full_frame();
    int cyc;
    cyc = 1;
    in_valid0 = 1'b1;
    out_ready0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (wr_idx0 !== 3'(i) || wr_en0 !== 1'b1 || busy0 !== 1'b0) begin
        n_errors++; $display("FAIL frame_load[%0d]: wr_idx=%0d wr_en=%b busy=%b required %0d 1 0", i, wr_idx0, wr_en0, busy0, i);
      end
      tick(); cyc++;
    end
    in_valid0 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (cap_q0 !== {1'b0, 1'(k % 2)} || wb_en0 !== 1'(k % 2) || stg0 !== 2'(k / 8) ||
          pr_idx0 !== 2'((k / 2) % 4) || busy0 !== 1'b1 || out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
        n_errors++; $display("FAIL frame_compute[%0d]: cap=%0d wb=%b stg=%0d pr=%0d busy=%b ov=%b ir=%b required cap=%0d wb=%0d stg=%0d pr=%0d",
          k, cap_q0, wb_en0, stg0, pr_idx0, busy0, out_valid0, in_ready0, k % 2, k % 2, k / 8, (k / 2) % 4);
      end
      tick(); cyc++;
    end
    n_checks++;
    if (out_valid0 !== 1'b1 || rd_idx0 !== 3'd0 || cap_q0 !== 2'd3 || stg0 !== 2'd0) begin
      n_errors++; $display("FAIL frame_out_start: ov=%b rd=%0d cap=%0d stg=%0d required 1 0 3 0", out_valid0, rd_idx0, cap_q0, stg0);
    end
    out_ready0 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (rd_idx0 !== 3'(j) || out_valid0 !== 1'b1 || done0 !== 1'b0) begin
        n_errors++; $display("FAIL frame_out[%0d]: rd=%0d ov=%b done=%b required %0d 1 0", j, rd_idx0, out_valid0, done0, j);
      end
      tick(); cyc++;
    end
    out_ready0 = 1'b0;
    n_checks++;
    if (done0 !== 1'b1 || cyc != 41 || in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_errors++; $display("FAIL frame_done: done=%b cyc=%0d ir=%b ov=%b busy=%b required 1 41 1 0 0", done0, cyc, in_ready0, out_valid0, busy0);
    end
    tick();
    n_checks++;
    if (done0 !== 1'b0) begin
      n_errors++; $display("FAIL frame_done_pulse: done=%b required 0", done0);
    end
  endtask

  task automatic test_gapped_input();
    int acc;
    acc = 0;
    for (int c = 0; c < 15; c++) begin
      in_valid0 = (c % 2 == 0);
      #1;
      n_checks++;
      if (wr_idx0 !== 3'(acc) || wr_en0 !== in_valid0 || state0 !== S_LOAD) begin
        n_errors++; $display("FAIL gapped[%0d]: wr_idx=%0d wr_en=%b state=%0d required %0d %b 0", c, wr_idx0, wr_en0, state0, acc, in_valid0);
      end
      if (in_valid0) acc++;
      tick();
    end
    in_valid0 = 1'b0;
    n_checks++;
    if (state0 !== S_COMP || busy0 !== 1'b1 || cap_q0 !== 2'd0) begin
      n_errors++; $display("FAIL gapped_compute_start: state=%0d busy=%b cap=%0d required 1 1 0", state0, busy0, cap_q0);
    end
    pulse_reset();
  endtask

  task automatic test_output_stall();
    in_valid0 = 1'b1;
    repeat (8) tick();
    in_valid0 = 1'b0;
    repeat (24) tick();
    out_ready0 = 1'b1;
    repeat (3) tick();
    out_ready0 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      n_checks++;
      if (rd_idx0 !== 3'd3 || out_valid0 !== 1'b1) begin
        n_errors++; $display("FAIL stall[%0d]: rd=%0d ov=%b required 3 1", s, rd_idx0, out_valid0);
      end
    end
    out_ready0 = 1'b1;
    for (int j = 3; j < 8; j++) begin
      n_checks++;
      if (rd_idx0 !== 3'(j) || out_valid0 !== 1'b1) begin
        n_errors++; $display("FAIL stall_release[%0d]: rd=%0d ov=%b required %0d 1", j, rd_idx0, out_valid0, j);
      end
      tick();
    end
    out_ready0 = 1'b0;
    n_checks++;
    if (done0 !== 1'b1 || state0 !== S_LOAD) begin
      n_errors++; $display("FAIL stall_done: done=%b state=%0d required 1 0", done0, state0);
    end
    tick();
  endtask

  task automatic test_overlap();
    in_valid0 = 1'b1;
    out_ready0 = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (wr_en0 !== 1'b0 || in_ready0 !== 1'b0) begin
        n_errors++; $display("FAIL overlap_blocked[%0d]: wr_en=%b ir=%b required 0 0", k, wr_en0, in_ready0);
      end
      tick();
    end
    n_checks++;
    if (done0 !== 1'b1 || wr_en0 !== 1'b1 || wr_idx0 !== 3'd0) begin
      n_errors++; $display("FAIL overlap_done_cycle: done=%b wr_en=%b wr_idx=%0d required 1 1 0", done0, wr_en0, wr_idx0);
    end
    tick();
    n_checks++;
    if (wr_idx0 !== 3'd1 || done0 !== 1'b0) begin
      n_errors++; $display("FAIL overlap_next: wr_idx=%0d done=%b required 1 0", wr_idx0, done0);
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b0;
    pulse_reset();
  endtask

  task automatic test_nstage1();
    int cyc;
    cyc = 1;
    in_valid1 = 1'b1;
    repeat (8) begin tick(); cyc++; end
    in_valid1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (state1 !== S_COMP || stg1 !== 2'd0 || pr_idx1 !== 2'(k / 2) || cap_q1 !== {1'b0, 1'(k % 2)} || wb_en1 !== 1'(k % 2)) begin
        n_errors++; $display("FAIL ns1_compute[%0d]: state=%0d stg=%0d pr=%0d cap=%0d wb=%b required 1 0 %0d %0d %0d",
          k, state1, stg1, pr_idx1, cap_q1, wb_en1, k / 2, k % 2, k % 2);
      end
      tick(); cyc++;
    end
    n_checks++;
    if (out_valid1 !== 1'b1 || rd_idx1 !== 3'd0) begin
      n_errors++; $display("FAIL ns1_out_start: ov=%b rd=%0d required 1 0", out_valid1, rd_idx1);
    end
    out_ready1 = 1'b1;
    repeat (8) begin tick(); cyc++; end
    out_ready1 = 1'b0;
    n_checks++;
    if (done1 !== 1'b1 || cyc != 25 || in_ready1 !== 1'b1) begin
      n_errors++; $display("FAIL ns1_done: done=%b cyc=%0d ir=%b required 1 25 1", done1, cyc, in_ready1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped_input();
    test_output_stall();
    test_overlap();
    test_nstage1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
